// File: rtl/sram_responder.sv
// Unified inst/data SRAM responder: shared word array, 1-cycle registered reads, post-reset clear.
// Optional `SRAM_PERF_CNT_EN adds rd_cnt/wr_cnt access counters.
module sram_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h1c00_0000,
  parameter int unsigned AW        = 14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        oor_err
`ifdef SRAM_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int unsigned Depth    = 1 << AW;
  // 33 bits so the window size never overflows, even for AW=30
  localparam logic [32:0] WinBytes = 33'(1) << (AW + 2);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e          r_state;
  logic [AW-1:0]   r_init_ptr;
  logic            r_init_done;
  logic            r_oor_err;
  logic [31:0]     r_inst_rdata;
  logic [31:0]     r_data_rdata;
  logic [31:0]     r_mem [Depth];

  logic [31:0]     w_inst_off;
  logic [31:0]     w_data_off;
  logic            w_inst_in;
  logic            w_data_in;
  logic [AW-1:0]   w_inst_idx;
  logic [AW-1:0]   w_data_idx;
  logic            w_ready;
  logic            w_inst_wr;
  logic            w_data_wr;
  logic [31:0]     w_inst_rd;
  logic [31:0]     w_data_rd;

  assign w_inst_off = inst_sram_addr - ADDR_BASE;
  assign w_data_off = data_sram_addr - ADDR_BASE;
  assign w_inst_in  = {1'b0, w_inst_off} < WinBytes;
  assign w_data_in  = {1'b0, w_data_off} < WinBytes;
  assign w_inst_idx = w_inst_off[AW+1:2];
  assign w_data_idx = w_data_off[AW+1:2];

  assign w_ready    = (r_state == StReady);
  assign w_inst_wr  = w_ready & inst_sram_we & w_inst_in;
  assign w_data_wr  = w_ready & data_sram_we & w_data_in;

  // Write-first read data; data port is checked first because it wins a collision.
  always_comb begin
    w_inst_rd = 32'h0;
    w_data_rd = 32'h0;
    if (w_inst_in) begin
      if (w_data_wr && (w_data_idx == w_inst_idx)) begin
        w_inst_rd = data_sram_wdata;
      end else if (w_inst_wr) begin
        w_inst_rd = inst_sram_wdata;
      end else begin
        w_inst_rd = r_mem[w_inst_idx];
      end
    end
    if (w_data_in) begin
      if (w_data_wr) begin
        w_data_rd = data_sram_wdata;
      end else if (w_inst_wr && (w_inst_idx == w_data_idx)) begin
        w_data_rd = inst_sram_wdata;
      end else begin
        w_data_rd = r_mem[w_data_idx];
      end
    end
  end

  // Array has no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (r_state == StInit) begin
      r_mem[r_init_ptr] <= 32'h0;
    end else begin
      if (w_inst_wr) begin
        r_mem[w_inst_idx] <= inst_sram_wdata;
      end
      if (w_data_wr) begin
        r_mem[w_data_idx] <= data_sram_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StInit;
      r_init_ptr   <= '0;
      r_init_done  <= 1'b0;
      r_oor_err    <= 1'b0;
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_inst_rdata <= 32'h0;
          r_data_rdata <= 32'h0;
          r_init_ptr   <= r_init_ptr + 1'b1;
          if (&r_init_ptr) begin
            r_state     <= StReady;
            r_init_done <= 1'b1;
          end
        end
        StReady: begin
          r_inst_rdata <= w_inst_rd;
          r_data_rdata <= w_data_rd;
          if (!w_inst_in || !w_data_in) begin
            r_oor_err <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SRAM_PERF_CNT_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [1:0]  w_rd_inc;
  logic [1:0]  w_wr_inc;

  // A port with we=1 is a write that cycle, not a read
  assign w_rd_inc = {1'b0, w_inst_in & ~inst_sram_we} + {1'b0, w_data_in & ~data_sram_we};
  assign w_wr_inc = {1'b0, w_inst_wr} + {1'b0, w_data_wr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_cnt <= 32'h0;
      r_wr_cnt <= 32'h0;
    end else if (w_ready) begin
      r_rd_cnt <= r_rd_cnt + {30'h0, w_rd_inc};
      r_wr_cnt <= r_wr_cnt + {30'h0, w_wr_inc};
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`endif

  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;
  assign init_done       = r_init_done;
  assign oor_err         = r_oor_err;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: expected read data queued at drive time, popped one edge later.
module tb_sram_responder;

  localparam logic [31:0] Base = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        init_done;
  logic        oor_err;
`ifdef SRAM_PERF_CNT_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] rd0;
  logic [31:0] wr0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  string       q_tag[$];
  bit          q_port[$];
  logic [31:0] q_exp[$];

  sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .init_done       (init_done),
    .oor_err         (oor_err)
`ifdef SRAM_PERF_CNT_EN
    ,
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic iwe, input logic [31:0] ia, input logic [31:0] iw,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dw);
    inst_sram_we    = iwe;
    inst_sram_addr  = ia;
    inst_sram_wdata = iw;
    data_sram_we    = dwe;
    data_sram_addr  = da;
    data_sram_wdata = dw;
  endtask

  task automatic idle();
    drive(1'b0, Base, 32'h0, 1'b0, Base, 32'h0);
  endtask

  task automatic push(input bit port, input logic [31:0] exp, input string tag);
    q_port.push_back(port);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  // One edge, then compare every queued expectation against the port it names.
  task automatic cycle();
    @(posedge clk);
    #1;
    while (q_exp.size() > 0) begin
      bit          p;
      logic [31:0] e;
      string       t;
      p = q_port.pop_front();
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      check(t, p ? data_sram_rdata : inst_sram_rdata, e);
    end
  endtask

  // Counts edges until init_done; attempts writes mid-clear that must be dropped.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 50) drive(1'b1, Base + 32'h10, 32'h7777_7777, 1'b1, Base + 32'h20, 32'h8888_8888);
      else if (n == 51) idle();
      if (n == 60) check("init_rdata", data_sram_rdata, 32'h0);
    end
  endtask

  initial begin
    int          n;
    int unsigned widx[8];
    logic [31:0] wv[8];

    idle();
    resetn = 1'b0;
    #12;
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_oor", {31'h0, oor_err}, 32'h0);
    check("rst_irdata", inst_sram_rdata, 32'h0);
    check("rst_drdata", data_sram_rdata, 32'h0);
    @(negedge clk) resetn = 1'b1;
    wait_init(n);
    check("init_edges", 32'(n), 32'd16384);

    // First reads after clear, including words targeted by dropped INIT writes
    drive(1'b0, Base, 32'h0, 1'b0, Base, 32'h0);
    push(0, 32'h0, "s1_inst"); push(1, 32'h0, "s1_data");
    cycle();
    drive(1'b0, Base + 32'h10, 32'h0, 1'b0, Base + 32'h20, 32'h0);
    push(0, 32'h0, "init_wr_drop_i"); push(1, 32'h0, "init_wr_drop_d");
    cycle();

    // Write then read across ports, low address bits ignored
    drive(1'b0, Base, 32'h0, 1'b1, Base + 32'h10, 32'hdead_beef);
    push(1, 32'hdead_beef, "s2_wfirst");
    cycle();
    drive(1'b0, Base + 32'h10, 32'h0, 1'b0, Base, 32'h0);
    push(0, 32'hdead_beef, "s2_inst");
    cycle();
    drive(1'b0, Base + 32'h13, 32'h0, 1'b0, Base + 32'h12, 32'h0);
    push(0, 32'hdead_beef, "s2_low_i"); push(1, 32'hdead_beef, "s2_low_d");
    cycle();

    // Same-word collision: data port wins, both read ports see it at once
`ifdef SRAM_PERF_CNT_EN
    rd0 = rd_cnt;
    wr0 = wr_cnt;
`endif
    drive(1'b1, Base + 32'h20, 32'h1111_1111, 1'b1, Base + 32'h20, 32'h2222_2222);
    push(0, 32'h2222_2222, "s3_wf_i"); push(1, 32'h2222_2222, "s3_wf_d");
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, Base + 32'h20, 32'h0, 1'b0, Base + 32'h20, 32'h0);
      push(0, 32'h2222_2222, "s3_rd_i"); push(1, 32'h2222_2222, "s3_rd_d");
      cycle();
    end
`ifdef SRAM_PERF_CNT_EN
    check("s7_wr_cnt", wr_cnt - wr0, 32'd2);
    check("s7_rd_cnt", rd_cnt - rd0, 32'd20);
`endif

    // Read-during-write from the other port, both directions
    drive(1'b0, Base + 32'h40, 32'h0, 1'b1, Base + 32'h40, 32'h0000_00a5);
    push(0, 32'h0000_00a5, "s4_raw_i");
    cycle();
    drive(1'b1, Base + 32'h80, 32'h1234_5678, 1'b0, Base + 32'h80, 32'h0);
    push(1, 32'h1234_5678, "iwr_raw_d");
    cycle();
    drive(1'b0, Base, 32'h0, 1'b0, Base + 32'h80, 32'h0);
    push(1, 32'h1234_5678, "iwr_back");
    cycle();

    // Scattered writes alternating ports, read back through the other port
    for (int i = 0; i < 8; i++) begin
      widx[i] = 32'((i * 37 + 3) % 16384);
      wv[i]   = $urandom;
      if (i % 2 == 1) drive(1'b1, Base + widx[i] * 4, wv[i], 1'b0, Base, 32'h0);
      else drive(1'b0, Base, 32'h0, 1'b1, Base + widx[i] * 4, wv[i]);
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        drive(1'b0, Base, 32'h0, 1'b0, Base + widx[i] * 4, 32'h0);
        push(1, wv[i], "rand_d");
      end else begin
        drive(1'b0, Base + widx[i] * 4, 32'h0, 1'b0, Base, 32'h0);
        push(0, wv[i], "rand_i");
      end
      cycle();
    end

    // Last in-range word
    drive(1'b0, Base, 32'h0, 1'b1, Base + 32'hfffc, 32'hcafe_f00d);
    cycle();
    drive(1'b0, Base + 32'hfffc, 32'h0, 1'b0, Base, 32'h0);
    push(0, 32'hcafe_f00d, "last_word");
    cycle();
    check("oor_clear", {31'h0, oor_err}, 32'h0);

    // First out-of-range address: write dropped, read 0, sticky flag
    drive(1'b0, Base, 32'h0, 1'b1, Base + 32'h1_0000, 32'h5);
    push(1, 32'h0, "s5_oor_rd");
    cycle();
    check("s5_oor_set", {31'h0, oor_err}, 32'h1);
    drive(1'b0, Base, 32'h0, 1'b0, Base + 32'h1_0000, 32'h0);
    push(0, 32'h0, "s5_mem0"); push(1, 32'h0, "s5_oor_rd2");
    cycle();
    drive(1'b0, Base - 32'h4, 32'h0, 1'b0, Base, 32'h0);
    push(0, 32'h0, "below_base");
    cycle();
    idle();
    repeat (3) cycle();
    check("s5_oor_hold", {31'h0, oor_err}, 32'h1);

    // Async reset in READY drops outputs immediately
    drive(1'b0, Base + 32'h10, 32'h0, 1'b0, Base, 32'h0);
    push(0, 32'hdead_beef, "pre_rst");
    cycle();
    idle();
    #2 resetn = 1'b0;
    #1;
    check("rst2_irdata", inst_sram_rdata, 32'h0);
    check("rst2_init_done", {31'h0, init_done}, 32'h0);
    check("rst2_oor", {31'h0, oor_err}, 32'h0);
    @(negedge clk) resetn = 1'b1;

    // Abort INIT at cycle 100, then a full clear must follow
    repeat (100) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst3_init_done", {31'h0, init_done}, 32'h0);
    @(negedge clk) resetn = 1'b1;
    wait_init(n);
    check("init2_edges", 32'(n), 32'd16384);
    drive(1'b0, Base + 32'h10, 32'h0, 1'b0, Base + 32'h20, 32'h0);
    push(0, 32'h0, "s6_clear_10"); push(1, 32'h0, "s6_clear_20");
    cycle();
    drive(1'b0, Base + 32'h40, 32'h0, 1'b0, Base + 32'hfffc, 32'h0);
    push(0, 32'h0, "s6_clear_40"); push(1, 32'h0, "s6_clear_last");
    cycle();
    check("s6_oor", {31'h0, oor_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
